// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle ARM controller sequencer with memory wait states and FPU start/done handshake.
// Define FPU_TIMEOUT_EN to enable the FPUEX watchdog (FpuAbort pulse, sticky FpuErr).
module mc_ctrl_fsm #(
  parameter int FPU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  input  logic       FpuDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       FPUW,
  output logic       Branch,
  output logic       FpuStart,
  output logic       FpuAbort,
  output logic       FpuErr
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, FPUEX, FPUWB
  } state_e;

  state_e r_state, w_next;
  logic   r_fpu_busy;
  logic   w_abort;
  logic   w_unused;

  assign w_unused = &{1'b0, Funct[4:1], FPU_TIMEOUT[0]};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= FETCH;
      r_fpu_busy <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fpu_busy <= r_state == FPUEX && w_next == FPUEX;
    end

`ifdef FPU_TIMEOUT_EN
  logic [6:0] r_cnt;
  logic       r_err;
  assign w_abort = r_state == FPUEX && !FpuDone && r_cnt == 7'(FPU_TIMEOUT - 1);
  assign FpuErr  = r_err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == FPUEX && w_next == FPUEX) ? r_cnt + 7'd1 : '0;
      if (w_abort) r_err <= 1'b1;
    end
`else
  assign w_abort = 1'b0;
  assign FpuErr  = 1'b0;
`endif

  assign FpuAbort = w_abort;

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = MemReady ? DECODE : FETCH;
      DECODE: w_next = Op == 2'b01 ? MEMADR :
                       Op == 2'b10 ? BRANCH :
                       Op == 2'b11 ? FPUEX  :
                       Funct[5]    ? EXECI  : EXECR;
      MEMADR: w_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  w_next = MemReady ? MEMWB : MEMRD;
      MEMWR:  w_next = MemReady ? FETCH : MEMWR;
      EXECR:  w_next = ALUWB;
      EXECI:  w_next = ALUWB;
      FPUEX:  w_next = FpuDone ? FPUWB : w_abort ? FETCH : FPUEX;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    FPUW      = 1'b0;
    Branch    = 1'b0;
    FpuStart  = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: ALUOp = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      FPUEX: FpuStart = !r_fpu_busy;
      FPUWB: begin
        ResultSrc = 2'b11;
        FPUW      = 1'b1;
      end
      default: ;
    endcase
    // Enables must be quiet while reset is held, even though FETCH decodes MemReady.
    if (!reset) begin
      IRWrite  = 1'b0;
      NextPC   = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
      FPUW     = 1'b0;
      Branch   = 1'b0;
      FpuStart = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm; expected output words are queued per driven cycle.
// Timeout scenarios run only when FPU_TIMEOUT_EN is defined.
module tb_mc_ctrl_fsm;
  typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FPUEX, S_FPUWB} st_e;
  typedef struct {string tag; logic [15:0] exp;} item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       MemReady = 1'b0;
  logic       FpuDone = 1'b0;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, FPUW, Branch;
  logic       FpuStart, FpuAbort, FpuErr;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [15:0] w_out;
  item_t      q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         tb_err = 0;

  mc_ctrl_fsm #(.FPU_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady), .FpuDone(FpuDone),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FPUW(FPUW),
    .Branch(Branch), .FpuStart(FpuStart), .FpuAbort(FpuAbort), .FpuErr(FpuErr)
  );

  always #5 clk = ~clk;

  assign w_out = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, NextPC,
                  RegW, MemW, FPUW, Branch, FpuStart, FpuAbort, FpuErr};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_out(st_e s, bit mr, bit st, bit ab, bit er, bit rs);
    logic [15:0] v;
    v = '0;
    case (s)
      S_FETCH:  v = {mr, 1'b0, 1'b1, 2'b10, 1'b0, 2'b10, mr, 7'b0};
      S_DECODE: v = {1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 8'b0};
      S_MEMADR: v[12:11] = 2'b01;
      S_MEMRD:  v[14] = 1'b1;
      S_MEMWB:  begin v[9:8] = 2'b01; v[6] = 1'b1; end
      S_MEMWR:  begin v[14] = 1'b1; v[5] = 1'b1; end
      S_EXECR:  v[10] = 1'b1;
      S_EXECI:  begin v[12:11] = 2'b01; v[10] = 1'b1; end
      S_ALUWB:  v[6] = 1'b1;
      S_BRANCH: begin v[12:11] = 2'b01; v[9:8] = 2'b10; v[3] = 1'b1; end
      S_FPUWB:  begin v[9:8] = 2'b11; v[4] = 1'b1; end
      default:  ;
    endcase
    v[2] = st;
    v[1] = ab;
    v[0] = er;
    if (rs) v = v & 16'b0111_1111_0000_0000;
    return v;
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      chk(it.tag, w_out, it.exp);
    end

  task automatic cyc(input string tag, input st_e s, input logic [1:0] op, input logic [5:0] fn,
                     input bit mr, input bit fd, input bit st = 0, input bit ab = 0);
    item_t it;
    Op = op;
    Funct = fn;
    MemReady = mr;
    FpuDone = fd;
    it.tag = tag;
    it.exp = exp_out(s, mr, st, ab, tb_err, !reset);
    q.push_back(it);
    @(negedge clk);
    @(posedge clk);
    #1;
    if (ab) tb_err = 1;
  endtask

  function automatic logic [1:0] r2();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic bit r1();
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    cyc("rst0", S_FETCH, 2'b00, 6'd0, 1, 0);
    cyc("rst1", S_FETCH, 2'b01, 6'd1, 1, 1);
    reset = 1'b1;
    // ADD register and immediate
    cyc("add_f", S_FETCH, 2'b00, 6'd0, 1, 0);
    cyc("add_d", S_DECODE, 2'b00, 6'b000000, r1(), r1());
    cyc("add_x", S_EXECR, r2(), r6(), r1(), r1());
    cyc("add_wb", S_ALUWB, r2(), r6(), r1(), r1());
    cyc("addi_f0", S_FETCH, r2(), r6(), 0, r1());
    cyc("addi_f1", S_FETCH, r2(), r6(), 1, r1());
    cyc("addi_d", S_DECODE, 2'b00, 6'b100000, r1(), r1());
    cyc("addi_x", S_EXECI, r2(), r6(), r1(), r1());
    cyc("addi_wb", S_ALUWB, r2(), r6(), r1(), r1());
    // Branch
    cyc("br_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("br_d", S_DECODE, 2'b10, r6(), r1(), r1());
    cyc("br_x", S_BRANCH, r2(), r6(), r1(), r1());
    // LDR with three wait states
    cyc("ldr_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("ldr_d", S_DECODE, 2'b01, 6'b000001, r1(), r1());
    cyc("ldr_a", S_MEMADR, 2'b01, 6'b000001, r1(), r1());
    for (int i = 0; i < 3; i++) cyc("ldr_wait", S_MEMRD, r2(), r6(), 0, r1());
    cyc("ldr_rd", S_MEMRD, r2(), r6(), 1, r1());
    cyc("ldr_wb", S_MEMWB, r2(), r6(), r1(), r1());
    // STR with two wait states
    cyc("str_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("str_d", S_DECODE, 2'b01, 6'b000000, r1(), r1());
    cyc("str_a", S_MEMADR, 2'b01, 6'b000000, r1(), r1());
    for (int i = 0; i < 2; i++) cyc("str_wait", S_MEMWR, r2(), r6(), 0, r1());
    cyc("str_wr", S_MEMWR, r2(), r6(), 1, r1());
    // FP op, done five cycles after start
    cyc("fp_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("fp_d", S_DECODE, 2'b11, r6(), r1(), r1());
    cyc("fp_start", S_FPUEX, r2(), r6(), r1(), 0, 1);
    for (int i = 0; i < 4; i++) cyc("fp_wait", S_FPUEX, r2(), r6(), r1(), 0);
    cyc("fp_done", S_FPUEX, r2(), r6(), r1(), 1);
    cyc("fp_wb", S_FPUWB, r2(), r6(), r1(), r1());
    // FP op, done on the start cycle
    cyc("fp0_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("fp0_d", S_DECODE, 2'b11, r6(), r1(), r1());
    cyc("fp0_start", S_FPUEX, r2(), r6(), r1(), 1, 1);
    cyc("fp0_wb", S_FPUWB, r2(), r6(), r1(), r1());
`ifdef FPU_TIMEOUT_EN
    // Done on the timeout cycle wins over abort
    cyc("fpd_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("fpd_d", S_DECODE, 2'b11, r6(), r1(), r1());
    cyc("fpd_start", S_FPUEX, r2(), r6(), r1(), 0, 1);
    for (int i = 0; i < 6; i++) cyc("fpd_wait", S_FPUEX, r2(), r6(), r1(), 0);
    cyc("fpd_done", S_FPUEX, r2(), r6(), r1(), 1);
    cyc("fpd_wb", S_FPUWB, r2(), r6(), r1(), r1());
    // FpuDone never arrives: abort on 8th FPUEX cycle
    cyc("fpt_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("fpt_d", S_DECODE, 2'b11, r6(), r1(), r1());
    cyc("fpt_start", S_FPUEX, r2(), r6(), r1(), 0, 1);
    for (int i = 0; i < 6; i++) cyc("fpt_wait", S_FPUEX, r2(), r6(), r1(), 0);
    cyc("fpt_abort", S_FPUEX, r2(), r6(), r1(), 0, 0, 1);
    cyc("fpt_f2", S_FETCH, 2'b00, r6(), 1, r1());
    cyc("fpt_d2", S_DECODE, 2'b00, 6'b000000, r1(), r1());
    cyc("fpt_x2", S_EXECR, r2(), r6(), r1(), r1());
    cyc("fpt_wb2", S_ALUWB, r2(), r6(), r1(), r1());
`endif
    // Reset asserted mid-MEMWR
    cyc("rs_f", S_FETCH, r2(), r6(), 1, r1());
    cyc("rs_d", S_DECODE, 2'b01, 6'b000000, r1(), r1());
    cyc("rs_a", S_MEMADR, 2'b01, 6'b000000, r1(), r1());
    MemReady = 1'b0;
    #1;
    chk("rs_memw_pre", {15'b0, MemW}, 16'd1);
    reset = 1'b0;
    tb_err = 0;
    #1;
    chk("rs_memw_async", {15'b0, MemW}, 16'd0);
    @(posedge clk);
    #1;
    cyc("rs_hold", S_FETCH, r2(), r6(), 1, r1());
    reset = 1'b1;
    cyc("rs_f0", S_FETCH, r2(), r6(), 0, r1());
    cyc("rs_f1", S_FETCH, r2(), r6(), 1, r1());
    cyc("rs_d2", S_DECODE, 2'b00, 6'b000000, r1(), r1());
    cyc("rs_x", S_EXECR, r2(), r6(), r1(), r1());
    cyc("rs_wb", S_ALUWB, r2(), r6(), r1(), r1());
    cyc("rs_end", S_FETCH, r2(), r6(), 0, r1());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
